// File: rtl/word_serializer_p.sv
// Splits IN_W-bit words into IN_W/OUT_W slices of OUT_W bits, one slice per output beat.
// Supports either slice order, downstream backpressure, a last-slice marker and gap-free word streaming.
module word_serializer_p #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  Data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [OUT_W-1:0] Data_out,
    output logic             last_out,
    input  logic             ready_out
);

    localparam int N     = IN_W / OUT_W;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [IN_W-1:0]    r_hold;
    logic [IN_W-1:0]    w_hold;
    logic [OUT_W-1:0]   r_data;
    logic [OUT_W-1:0]   w_data;
    logic               r_last;
    logic               w_last;
    logic               w_take;

    // Slice k of a word, counted in output order.
    function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] word,
                                                  input logic [CNT_W-1:0] k);
        int shift;
        if (MSB_FIRST != 0) begin
            shift = (N - 1 - int'(k)) * OUT_W;
        end else begin
            shift = int'(k) * OUT_W;
        end
        return OUT_W'(word >> shift);
    endfunction

    // A new word fits when nothing is shown, or the last slice leaves on this edge.
    assign ready_in  = (r_state == S_IDLE) || (ready_out && (r_cnt == LAST_CNT));
    assign w_take    = valid_in && ready_in;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    assign valid_out = (r_state == S_SHIFT);
    assign Data_out  = r_data;
    assign last_out  = r_last;

    // Next-state and next-output selection for the IDLE/SHIFT control.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_hold  = r_hold;
        w_data  = r_data;
        w_last  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_state = S_SHIFT;
                    w_hold  = Data_in;
                    w_data  = slice_of(Data_in, CNT_W'(0));
                    w_cnt   = CNT_W'(0);
                    w_last  = 1'b0;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (!ready_out) begin
                    w_state = S_SHIFT;
                end else if (r_cnt != LAST_CNT) begin
                    w_cnt  = w_cnt_inc;
                    w_data = slice_of(r_hold, w_cnt_inc);
                    w_last = (w_cnt_inc == LAST_CNT);
                end else if (w_take) begin
                    // Last slice leaves and the next word loads on the same edge.
                    w_state = S_SHIFT;
                    w_hold  = Data_in;
                    w_data  = slice_of(Data_in, CNT_W'(0));
                    w_cnt   = CNT_W'(0);
                    w_last  = 1'b0;
                end else begin
                    w_state = S_IDLE;
                    w_data  = {OUT_W{1'b0}};
                    w_cnt   = CNT_W'(0);
                    w_last  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_data  = {OUT_W{1'b0}};
                w_cnt   = CNT_W'(0);
                w_last  = 1'b0;
            end
        endcase
    end

    // State, counter, holding word and registered outputs.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_W'(0);
            r_hold  <= {IN_W{1'b0}};
            r_data  <= {OUT_W{1'b0}};
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_hold  <= w_hold;
            r_data  <= w_data;
            r_last  <= w_last;
        end
    end

endmodule
